// File: rtl/stub_feed_fifo.sv
// -----------------------------------------------------------------------------
// stub_feed_fifo
//
// Small synchronous FIFO that buffers bytes from an upstream valid/ready
// producer and presents them to a downstream valid/ready consumer. Outputs are
// driven from registered state only: there is no same-cycle bypass from
// s_data_i to m_data_o, and no combinational path from m_ready_i to s_ready_o.
//
// Parameters
//   WIDTH      data width in bits
//   DEPTH      number of storage entries (power of two, >= 2)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   s_valid_i  upstream byte offered
//   s_data_i   upstream byte
//   s_ready_o  FIFO can accept a byte (== !full_o)
//   m_valid_o  head byte presented downstream (== !empty_o)
//   m_data_o   head byte (reads 0 while empty)
//   m_ready_i  downstream consumer accepts the head byte
//   level_o    number of stored entries, 0..DEPTH
//   full_o     level_o == DEPTH
//   empty_o    level_o == 0
// -----------------------------------------------------------------------------
module stub_feed_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid_i,
  input  logic [WIDTH-1:0]         s_data_i,
  output logic                     s_ready_o,
  output logic                     m_valid_o,
  output logic [WIDTH-1:0]         m_data_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;

  logic push;
  logic pop;

  // Status flags come straight from the level counter, so they change on
  // the same edge as the push or pop that moves the level.
  assign full_o    = (level_q == LVL_MAX);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign s_ready_o = !full_o;
  assign m_valid_o = !empty_o;

  // Storage is not cleared by reset, so the head is masked while empty to
  // keep m_data_o at 0 after reset instead of showing stale contents.
  assign m_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign push = s_valid_i && s_ready_o;
  assign pop  = m_valid_o && m_ready_i;

  // NOTE: every signal written here gets its default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    // Pointers are exactly log2(DEPTH) bits wide, so the increment wraps
    // modulo DEPTH on its own.
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;  // idle, or push and pop together
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and level define what is
  // valid, so clearing the array would only add reset fan-out. Writes are
  // blocked on the reset edge so a reset never stores a byte.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

endmodule

// File: doc/stub_feed_fifo.md
STUB_FEED_FIFO -- requirements
Module: stub_feed_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data byte width in bits.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 s_valid_i  input  1  upstream byte offered.
REQ-006 s_data_i  input  WIDTH  upstream byte.
REQ-007 s_ready_o  output  1  block can accept a byte.
REQ-008 m_valid_o  output  1  byte presented to the downstream consumer (valid_i of the consumer).
REQ-009 m_data_o  output  WIDTH  byte to the downstream consumer (data_i of the consumer).
REQ-010 m_ready_i  input  1  downstream consumer accepts (ready_o of the consumer).
REQ-011 level_o  output  log2(DEPTH)+1  current number of stored entries.
REQ-012 full_o  output  1  level_o == DEPTH.
REQ-013 empty_o  output  1  level_o == 0.

Function
REQ-014 An upstream push SHALL occur on a cycle where s_valid_i && s_ready_o; the byte on s_data_i is written at the tail.
REQ-015 A downstream pop SHALL occur on a cycle where m_valid_o && m_ready_i; the head entry is removed.
REQ-016 s_ready_o SHALL equal !full_o, derived from registered state only, with no combinational path from m_ready_i.
REQ-017 m_valid_o SHALL equal !empty_o; m_data_o SHALL always present the head entry.
REQ-018 While m_valid_o=1 and m_ready_i=0, m_data_o and m_valid_o SHALL hold stable.
REQ-019 Latency: a byte pushed into an empty FIFO at edge N SHALL appear on m_valid_o/m_data_o after edge N; there is no same-cycle bypass.
REQ-020 Ordering SHALL be strict FIFO; no byte is dropped or duplicated.
REQ-021 Push and pop in the same cycle (not full, not empty): level_o SHALL be unchanged and both pointers advance.
REQ-022 When full, s_ready_o=0, so a simultaneous pop does not admit a push that cycle; the freed slot is offered on the next cycle.
REQ-023 When empty, a pop cannot occur, since m_valid_o=0 regardless of m_ready_i.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level_o is maintained as a separate counter, range 0..DEPTH.
REQ-025 full_o, empty_o and level_o SHALL be registered-consistent, and update on the same edge as the push or pop that changes them.
REQ-026 s_data_i SHALL be ignored when s_valid_i=0 or s_ready_o=0.

Reset
REQ-027 When rst_n=0 at a rising edge: pointers and level SHALL be set to 0, giving m_valid_o=0, empty_o=1, full_o=0, s_ready_o=1 and level_o=0 after that edge.
REQ-028 m_data_o SHALL read 0 after reset; storage contents need not be cleared.
REQ-029 A reset mid-operation SHALL discard all stored bytes, and no push or pop occurs on the reset edge.
REQ-030 Reset SHALL have no effect between clock edges; assertion without an edge changes no output.

Verification
REQ-031 Reset, then push 0x11 with m_ready_i=0 -> after one edge m_valid_o=1, m_data_o=0x11, level_o=1; m_data_o holds 0x11 across 5 stalled cycles.
REQ-032 Push 0xA0, 0xA1, 0xA2, 0xA3 with m_ready_i=0 -> full_o=1, s_ready_o=0, level_o=4; a fifth offer of 0xA4 is not accepted; then m_ready_i=1 drains 0xA0..0xA3 in order, then empty_o=1.
REQ-033 Full FIFO with s_valid_i=1 and m_ready_i=1 on the same cycle -> pop only, level_o=3; on the next cycle push accepted, level_o=4.
REQ-034 Continuous s_valid_i=1 and m_ready_i=1 streaming 0x00..0x0F -> outputs 0x00..0x0F in order, with pointers wrapping four times and level_o settling at 1 steady-state.
REQ-035 Load 3 bytes, assert rst_n=0 for one edge while s_valid_i=1 and m_ready_i=1 -> level_o=0, m_valid_o=0, and no byte consumed or stored on that edge.
REQ-036 Randomised valid/ready on both sides for 10000 cycles against a scoreboard queue -> zero mismatches, and level_o always in 0..4.
